// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences single core requests onto an edge-strobed 256x16 RAM.
// Each access runs setup -> strobe pulse -> hold from one clock, and the result
// is returned on a valid/ready response channel.
// Optional feature: define RAM_ACC_LIMIT_EN to reject addresses above ADDR_LIMIT
// without touching the RAM (rsp_err=1, response one cycle after accept).
module ram_access_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'hEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  // One shared down-counter, reloaded on every phase change.
  localparam int CNT_W = 8;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              we_q, we_q_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_data_d;
  logic              ram_cs_d, ram_we_d, ram_re_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              addr_bad;

`ifdef RAM_ACC_LIMIT_EN
  assign addr_bad = (req_addr > ADDR_LIMIT);
`else
  logic unused_limit;
  assign unused_limit = ^ADDR_LIMIT;
  assign addr_bad     = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Next-state and next-output logic; every RAM-facing output is computed here
  // and registered below so the edge-sensitive strobes never glitch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    we_q_d      = we_q;
    ram_addr_d  = ram_addr;
    ram_data_d  = ram_data;
    ram_cs_d    = ram_cs;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          we_q_d = req_we;
          if (addr_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = SETUP;
            cnt_d       = CNT_W'(SETUP_CYC - 1);
            ram_cs_d    = 1'b1;
            ram_addr_d  = req_addr;
            ram_data_d  = req_we ? req_wdata : '0;
            rsp_err_d   = 1'b0;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_d  = STROBE;
          cnt_d    = CNT_W'(PULSE_CYC - 1);
          ram_we_d = we_q;
          ram_re_d = ~we_q;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d    = cnt - 1'b1;
          ram_we_d = we_q;
          ram_re_d = ~we_q;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_d     = RESP;
          ram_cs_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : ram_q;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        ram_cs_d = 1'b0;
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and all outputs registered; reset drops everything at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      we_q      <= we_q_d;
      ram_addr  <= ram_addr_d;
      ram_data  <= ram_data_d;
      ram_cs    <= ram_cs_d;
      ram_we    <= ram_we_d;
      ram_re    <= ram_re_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule
